// File: rtl/axi4_lite_arbiter_2to1.sv
// Two-port AXI4-Lite arbiter onto one manager port. At most one write or read is outstanding on m_,
// ports are arbitrated round-robin, and a port that asks for both a write and a read gets the write first.
module axi4_lite_arbiter_2to1 #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    // subordinate port 0
    input  logic                      s0_awvalid,
    input  logic [ADDR_BYTES*8-1:0]   s0_awaddr,
    input  logic [2:0]                s0_awprot,
    output logic                      s0_awready,
    input  logic                      s0_wvalid,
    input  logic [DATA_BYTES*8-1:0]   s0_wdata,
    input  logic [DATA_BYTES-1:0]     s0_wstrb,
    output logic                      s0_wready,
    output logic                      s0_bvalid,
    output logic [1:0]                s0_bresp,
    input  logic                      s0_bready,
    input  logic                      s0_arvalid,
    input  logic [ADDR_BYTES*8-1:0]   s0_araddr,
    input  logic [2:0]                s0_arprot,
    output logic                      s0_arready,
    output logic                      s0_rvalid,
    output logic [DATA_BYTES*8-1:0]   s0_rdata,
    output logic [1:0]                s0_rresp,
    input  logic                      s0_rready,
    // subordinate port 1
    input  logic                      s1_awvalid,
    input  logic [ADDR_BYTES*8-1:0]   s1_awaddr,
    input  logic [2:0]                s1_awprot,
    output logic                      s1_awready,
    input  logic                      s1_wvalid,
    input  logic [DATA_BYTES*8-1:0]   s1_wdata,
    input  logic [DATA_BYTES-1:0]     s1_wstrb,
    output logic                      s1_wready,
    output logic                      s1_bvalid,
    output logic [1:0]                s1_bresp,
    input  logic                      s1_bready,
    input  logic                      s1_arvalid,
    input  logic [ADDR_BYTES*8-1:0]   s1_araddr,
    input  logic [2:0]                s1_arprot,
    output logic                      s1_arready,
    output logic                      s1_rvalid,
    output logic [DATA_BYTES*8-1:0]   s1_rdata,
    output logic [1:0]                s1_rresp,
    input  logic                      s1_rready,
    // manager port
    output logic                      m_awvalid,
    output logic [ADDR_BYTES*8-1:0]   m_awaddr,
    output logic [2:0]                m_awprot,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [DATA_BYTES*8-1:0]   m_wdata,
    output logic [DATA_BYTES-1:0]     m_wstrb,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic                      m_arvalid,
    output logic [ADDR_BYTES*8-1:0]   m_araddr,
    output logic [2:0]                m_arprot,
    input  logic                      m_arready,
    input  logic                      m_rvalid,
    input  logic [DATA_BYTES*8-1:0]   m_rdata,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready,
    output logic [1:0]                grant
);

    localparam int DW = DATA_BYTES * 8;
    localparam int AW = ADDR_BYTES * 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;

    logic [2:0] state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_grant_q, last_grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic       act;
    logic       busy;
    logic       wr_req0, wr_req1, req0, req1, pick;

    // Granted port's requests, selected by the registered owner.
    logic          sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic          up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
    logic [1:0]    up_bresp, up_rresp;
    logic [DW-1:0] up_rdata;

    // Every output is forced low while areset is high, even before the state register clears.
    assign act  = !areset;
    assign busy = act && (state_q != ST_IDLE);

    assign wr_req0 = s0_awvalid && s0_wvalid;
    assign wr_req1 = s1_awvalid && s1_wvalid;
    assign req0    = wr_req0 || s0_arvalid;
    assign req1    = wr_req1 || s1_arvalid;

    assign sel_awvalid = sel_q ? s1_awvalid : s0_awvalid;
    assign sel_wvalid  = sel_q ? s1_wvalid  : s0_wvalid;
    assign sel_bready  = sel_q ? s1_bready  : s0_bready;
    assign sel_arvalid = sel_q ? s1_arvalid : s0_arvalid;
    assign sel_rready  = sel_q ? s1_rready  : s0_rready;

    assign grant = busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        pick         = 1'b0;
        m_awvalid    = 1'b0;
        m_wvalid     = 1'b0;
        m_bready     = 1'b0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        up_awready   = 1'b0;
        up_wready    = 1'b0;
        up_bvalid    = 1'b0;
        up_bresp     = 2'b00;
        up_arready   = 1'b0;
        up_rvalid    = 1'b0;
        up_rdata     = '0;
        up_rresp     = 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    pick         = (req0 && req1) ? !last_grant_q : req1;
                    sel_d        = pick;
                    last_grant_d = pick;
                    state_d      = (pick ? wr_req1 : wr_req0) ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                m_awvalid  = act && sel_awvalid && !aw_done_q;
                up_awready = act && m_awready && !aw_done_q;
                m_wvalid   = act && sel_wvalid && !w_done_q;
                up_wready  = act && m_wready && !w_done_q;
                if (m_awvalid && m_awready) aw_done_d = 1'b1;
                if (m_wvalid && m_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)  state_d   = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_bready  = act && sel_bready;
                up_bvalid = act && m_bvalid;
                up_bresp  = act ? m_bresp : 2'b00;
                if (m_bvalid && m_bready) begin
                    state_d   = ST_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                m_arvalid  = act && sel_arvalid;
                up_arready = act && m_arready;
                if (m_arvalid && m_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_rready  = act && sel_rready;
                up_rvalid = act && m_rvalid;
                up_rdata  = act ? m_rdata : '0;
                up_rresp  = act ? m_rresp : 2'b00;
                if (m_rvalid && m_rready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_awaddr = '0;
        m_awprot = 3'b000;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_araddr = '0;
        m_arprot = 3'b000;
        if (busy) begin
            m_awaddr = sel_q ? s1_awaddr : s0_awaddr;
            m_awprot = sel_q ? s1_awprot : s0_awprot;
            m_wdata  = sel_q ? s1_wdata  : s0_wdata;
            m_wstrb  = sel_q ? s1_wstrb  : s0_wstrb;
            m_araddr = sel_q ? s1_araddr : s0_araddr;
            m_arprot = sel_q ? s1_arprot : s0_arprot;
        end
    end

    // Responses reach only the owner; the other port sees zeros.
    assign s0_awready = up_awready && !sel_q;
    assign s0_wready  = up_wready  && !sel_q;
    assign s0_bvalid  = up_bvalid  && !sel_q;
    assign s0_bresp   = sel_q ? 2'b00 : up_bresp;
    assign s0_arready = up_arready && !sel_q;
    assign s0_rvalid  = up_rvalid  && !sel_q;
    assign s0_rdata   = sel_q ? {DW{1'b0}} : up_rdata;
    assign s0_rresp   = sel_q ? 2'b00 : up_rresp;

    assign s1_awready = up_awready && sel_q;
    assign s1_wready  = up_wready  && sel_q;
    assign s1_bvalid  = up_bvalid  && sel_q;
    assign s1_bresp   = sel_q ? up_bresp : 2'b00;
    assign s1_arready = up_arready && sel_q;
    assign s1_rvalid  = up_rvalid  && sel_q;
    assign s1_rdata   = sel_q ? up_rdata : {DW{1'b0}};
    assign s1_rresp   = sel_q ? up_rresp : 2'b00;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    logic unused_aw;
    assign unused_aw = ^{AW[0]};

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for axi4_lite_arbiter_2to1: the bench plays both subordinate masters and the
// downstream slave, stepping one clock at a time with hand-computed expectations.
module tb_axi4_lite_arbiter_2to1;

    logic        aclk = 1'b0;
    logic        areset;

    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [2:0]  s0_awprot, s0_arprot;
    logic [3:0]  s0_wstrb;
    logic [1:0]  s0_bresp, s0_rresp;

    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
    logic [2:0]  s1_awprot, s1_arprot;
    logic [3:0]  s1_wstrb;
    logic [1:0]  s1_bresp, s1_rresp;

    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [1:0]  grant;

    int tests = 0;
    int fails = 0;
    int aw_hs = 0;
    int aw_base;

    logic s0_any, s1_any, m_any;
    assign s0_any = |{s0_awready, s0_wready, s0_bvalid, s0_bresp, s0_arready, s0_rvalid, s0_rdata, s0_rresp};
    assign s1_any = |{s1_awready, s1_wready, s1_bvalid, s1_bresp, s1_arready, s1_rvalid, s1_rdata, s1_rresp};
    assign m_any  = |{m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
                      m_arvalid, m_araddr, m_arprot, m_rready, grant};

    axi4_lite_arbiter_2to1 #(.DATA_BYTES(4), .ADDR_BYTES(4)) dut (
        .aclk(aclk), .areset(areset),
        .s0_awvalid(s0_awvalid), .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awready(s0_awready),
        .s0_wvalid(s0_wvalid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wready(s0_wready),
        .s0_bvalid(s0_bvalid), .s0_bresp(s0_bresp), .s0_bready(s0_bready),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
        .s1_awvalid(s1_awvalid), .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awready(s1_awready),
        .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wready(s1_wready),
        .s1_bvalid(s1_bvalid), .s1_bresp(s1_bresp), .s1_bready(s1_bready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rready(s1_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .grant(grant)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        areset = 1'b1;
        {s0_awvalid, s0_wvalid, s0_bready, s0_arvalid, s0_rready} = '0;
        {s1_awvalid, s1_wvalid, s1_bready, s1_arvalid, s1_rready} = '0;
        s0_awaddr = '0; s0_awprot = '0; s0_wdata = '0; s0_wstrb = '0; s0_araddr = '0; s0_arprot = '0;
        s1_awaddr = '0; s1_awprot = '0; s1_wdata = '0; s1_wstrb = '0; s1_araddr = '0; s1_arprot = '0;
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        m_bresp = '0; m_rresp = '0; m_rdata = '0;

        // Reset: outputs stay quiet even with live-looking inputs.
        step();
        s0_awvalid = 1'b1; s0_wvalid = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        step();
        settle();
        check("rst_grant", grant, 2'b00);
        check("rst_outputs", {s0_any, s1_any, m_any}, 3'b000);
        s0_awvalid = 1'b0; s0_wvalid = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        step();

        // s0 write with an always-ready slave.
        areset = 1'b0;
        s0_awvalid = 1'b1; s0_awaddr = 32'h10; s0_wvalid = 1'b1; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
        s0_bready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        settle();
        check("w0_pre_grant", grant, 2'b00);
        check("w0_pre_awvalid", m_awvalid, 1'b0);
        step();
        check("w0_grant", grant, 2'b01);
        check("w0_aw_w_valid", {m_awvalid, m_wvalid}, 2'b11);
        check("w0_awaddr", m_awaddr, 32'h10);
        check("w0_wdata", m_wdata, 32'hDEADBEEF);
        check("w0_wstrb", m_wstrb, 4'hF);
        check("w0_s0_ready", {s0_awready, s0_wready}, 2'b11);
        check("w0_s1_quiet", s1_any, 1'b0);
        step();
        s0_awvalid = 1'b0; s0_wvalid = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
        settle();
        check("w0_bvalid_bresp", {s0_bvalid, s0_bresp}, 3'b100);
        check("w0_bready", m_bready, 1'b1);
        check("w0_aw_done", m_awvalid, 1'b0);
        check("w0_s1_quiet_b", s1_any, 1'b0);
        step();
        m_bvalid = 1'b0; s0_bready = 1'b0;
        settle();
        check("w0_idle", grant, 2'b00);

        // Fresh reset, then s0 read against s1 write: s0 first.
        areset = 1'b1;
        step();
        areset = 1'b0;
        s0_arvalid = 1'b1; s0_araddr = 32'h20; s0_arprot = 3'b010;
        s1_awvalid = 1'b1; s1_wvalid = 1'b1; s1_awaddr = 32'h30; s1_wdata = 32'h1111_2222; s1_wstrb = 4'h3;
        m_arready = 1'b1;
        settle();
        check("tie1_pre", grant, 2'b00);
        step();
        check("tie1_grant", grant, 2'b01);
        check("tie1_arvalid", m_arvalid, 1'b1);
        check("tie1_araddr", m_araddr, 32'h20);
        check("tie1_arprot", m_arprot, 3'b010);
        check("tie1_no_aw", m_awvalid, 1'b0);
        check("tie1_s1_quiet", s1_any, 1'b0);
        step();
        s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hAAAA_5555; m_rresp = 2'b00; s0_rready = 1'b1;
        settle();
        check("tie1_rvalid", s0_rvalid, 1'b1);
        check("tie1_rdata", s0_rdata, 32'hAAAA_5555);
        check("tie1_rready", m_rready, 1'b1);
        step();
        m_rvalid = 1'b0; s0_rready = 1'b0;
        settle();
        check("tie1_gap", grant, 2'b00);
        step();
        check("s1w_grant", grant, 2'b10);
        check("s1w_awaddr", m_awaddr, 32'h30);
        check("s1w_wdata", m_wdata, 32'h1111_2222);
        check("s1w_awready", s1_awready, 1'b1);
        check("s1w_s0_quiet", s0_any, 1'b0);
        step();
        s1_awvalid = 1'b0; s1_wvalid = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b10; s1_bready = 1'b1;
        settle();
        check("s1w_slverr", {s1_bvalid, s1_bresp}, 3'b110);
        check("s1w_s0_bvalid", s0_bvalid, 1'b0);
        step();
        m_bvalid = 1'b0; s1_bready = 1'b0;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; s1_araddr = 32'h40;
        settle();
        check("tie2_pre", grant, 2'b00);
        step();
        check("tie2_grant", grant, 2'b01);
        step();
        s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rresp = 2'b11; s0_rready = 1'b1;
        settle();
        check("tie2_decerr", s0_rresp, 2'b11);
        step();
        m_rvalid = 1'b0; s0_rready = 1'b0;
        step();
        check("tie2_s1_grant", grant, 2'b10);
        check("tie2_s1_araddr", m_araddr, 32'h40);
        step();
        s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rresp = 2'b00; s1_rready = 1'b1;
        step();
        m_rvalid = 1'b0; s1_rready = 1'b0;
        settle();
        check("tie2_done", grant, 2'b00);

        // s1 write and read together: write first.
        s1_awvalid = 1'b1; s1_wvalid = 1'b1; s1_arvalid = 1'b1; s1_araddr = 32'h44;
        step();
        check("wr_first_grant", grant, 2'b10);
        check("wr_first_valids", {m_awvalid, m_arvalid}, 2'b10);
        step();
        s1_awvalid = 1'b0; s1_wvalid = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00; s1_bready = 1'b1;
        settle();
        check("wr_first_no_ar", {m_arvalid, s1_arready}, 2'b00);
        step();
        m_bvalid = 1'b0; s1_bready = 1'b0;
        settle();
        check("wr_first_gap", grant, 2'b00);
        step();
        check("rd_after_wr", {grant, m_arvalid}, 3'b101);
        step();
        s1_arvalid = 1'b0; m_rvalid = 1'b1; s1_rready = 1'b1;
        step();
        m_rvalid = 1'b0; s1_rready = 1'b0;

        // Delayed W ready: a single AW handshake, then W, then response.
        s0_awvalid = 1'b1; s0_wvalid = 1'b1; s0_awaddr = 32'h50; s0_wdata = 32'hCAFE_F00D;
        s0_bready = 1'b1; m_awready = 1'b1; m_wready = 1'b0;
        aw_base = aw_hs;
        step();
        check("dw_valids", {m_awvalid, m_wvalid}, 2'b11);
        step();
        check("dw_aw_dropped", {m_awvalid, s0_awready}, 2'b00);
        check("dw_w_held", m_wvalid, 1'b1);
        check("dw_no_bready", m_bready, 1'b0);
        step();
        check("dw_wait2", {grant, m_awvalid, m_wvalid}, 4'b0101);
        step();
        m_wready = 1'b1;
        settle();
        check("dw_wready", s0_wready, 1'b1);
        step();
        s0_awvalid = 1'b0; s0_wvalid = 1'b0;
        settle();
        check("dw_resp_state", m_bready, 1'b1);
        check("dw_one_aw_hs", aw_hs - aw_base, 1);
        m_bvalid = 1'b1;
        step();
        m_bvalid = 1'b0; s0_bready = 1'b0;

        // Reset while waiting for B with m_bvalid high.
        s1_awvalid = 1'b1; s1_wvalid = 1'b1;
        step();
        check("rstb_grant", grant, 2'b10);
        step();
        s1_awvalid = 1'b0; s1_wvalid = 1'b0; m_bvalid = 1'b1;
        settle();
        check("rstb_bvalid", s1_bvalid, 1'b1);
        areset = 1'b1;
        settle();
        check("rstb_during", {s0_any, s1_any, m_any}, 3'b000);
        step();
        areset = 1'b0;
        settle();
        check("rstb_after", {s0_any, s1_any, m_any}, 3'b000);
        m_bvalid = 1'b0;
        s0_arvalid = 1'b1; s0_araddr = 32'h60; s1_arvalid = 1'b1; s1_araddr = 32'h70;
        step();
        check("rstb_tie_grant", grant, 2'b01);
        check("rstb_tie_araddr", m_araddr, 32'h60);
        step();
        s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; m_rresp = 2'b00; s0_rready = 1'b1;
        step();
        m_rvalid = 1'b0; s0_rready = 1'b0;

        // s1 read with SLVERR and a slow consumer.
        step();
        check("slow_grant", grant, 2'b10);
        check("slow_araddr", m_araddr, 32'h70);
        step();
        s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rresp = 2'b10; s1_rready = 1'b0;
        settle();
        check("slow_r1", {s1_rvalid, s1_rresp, m_rready}, 4'b1100);
        check("slow_r1_data", s1_rdata, 32'h1234_5678);
        step();
        check("slow_r2", {s1_rvalid, m_rready}, 2'b10);
        check("slow_r2_data", s1_rdata, 32'h1234_5678);
        step();
        s1_rready = 1'b1;
        settle();
        check("slow_r3", {s1_rvalid, m_rready}, 2'b11);
        check("slow_r3_data", s1_rdata, 32'h1234_5678);
        step();
        m_rvalid = 1'b0; s1_rready = 1'b0;
        settle();
        check("slow_idle", grant, 2'b00);
        check("slow_s1_quiet", s1_any, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
